// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types, funct3 codes and request helpers for the memory stage
package mem_stage_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2,
      DONE = 2'd3
   } mem_state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } bus_req_t;

   // Misaligned halves/words and the unused funct3 codes are all suppressed the same way.
   function automatic logic access_illegal(input logic [2:0] f3, input logic [1:0] off);
      logic bad;
      case (f3)
         F3_B, F3_BU: bad = 1'b0;
         F3_H, F3_HU: bad = off[0];
         F3_W:        bad = (off != 2'b00);
         default:     bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Word-aligned request; stores replicate the data across lanes so the byte enables pick the lane.
   function automatic bus_req_t build_req(input logic we, input logic [31:0] addr,
                                          input logic [31:0] ws, input logic [2:0] f3);
      bus_req_t r;
      r.we    = we;
      r.addr  = {addr[31:2], 2'b00};
      r.wdata = ws;
      r.be    = 4'b1111;
      if (we) begin
         case (f3[1:0])
            2'b00: begin
               r.be    = 4'b0001 << addr[1:0];
               r.wdata = {4{ws[7:0]}};
            end
            2'b01: begin
               r.be    = 4'b0011 << addr[1:0];
               r.wdata = {2{ws[15:0]}};
            end
            default: begin
               r.be    = 4'b1111;
               r.wdata = ws;
            end
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/mem_load_extract.sv
// rtl/mem_load_extract.sv - selects and extends the loaded byte/half/word from a read word
module mem_load_extract
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select by byte offset, then sign- or zero-extend according to funct3.
   always_comb begin
      case (off_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   result_o = {24'h0, byte_sel};
         F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   result_o = {16'h0, half_sel};
         default: result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit driving the data-cache request/response port
module mem_access_unit
   import mem_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pipe_en,
   input  logic                  inst_valid_m,
   input  logic [DATA_WIDTH-1:0] ALUResult_m,
   input  logic [DATA_WIDTH-1:0] WriteData_m,
   input  logic                  MemRead_m,
   input  logic                  MemWrite_m,
   input  logic [2:0]            funct3_m,
   output logic [DATA_WIDTH-1:0] ReadData_m,
   output logic                  valid_m,
   output logic                  stall_m,
   output logic                  misalign_m,
   output logic                  bus_req_valid,
   input  logic                  bus_req_ready,
   output logic                  bus_req_we,
   output logic [DATA_WIDTH-1:0] bus_req_addr,
   output logic [DATA_WIDTH-1:0] bus_req_wdata,
   output logic [BE_WIDTH-1:0]   bus_req_be,
   input  logic                  bus_rsp_valid,
   input  logic [DATA_WIDTH-1:0] bus_rsp_rdata
);

   mem_state_t  state_q, state_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  f3_q, f3_d;
   bus_req_t    req_q, req_d;

   logic        mem_op;
   logic        illegal;
   bus_req_t    req_in;
   logic [31:0] load_result;

   assign mem_op  = MemRead_m | MemWrite_m;
   assign illegal = access_illegal(funct3_m, ALUResult_m[1:0]);
   assign req_in  = build_req(MemWrite_m, ALUResult_m, WriteData_m, funct3_m);

   mem_load_extract u_extract (
      .rdata_i  (rdata_q),
      .off_i    (off_q),
      .funct3_i (f3_q),
      .result_o (load_result)
   );

   // Next state, capture and outputs; the bus fields replay the captured request outside IDLE.
   always_comb begin
      state_d       = state_q;
      rdata_d       = rdata_q;
      off_d         = off_q;
      f3_d          = f3_q;
      req_d         = req_q;
      valid_m       = 1'b0;
      stall_m       = 1'b0;
      misalign_m    = 1'b0;
      ReadData_m    = '0;
      bus_req_valid = 1'b0;
      bus_req_we    = req_q.we;
      bus_req_addr  = req_q.addr;
      bus_req_wdata = req_q.wdata;
      bus_req_be    = req_q.be;
      case (state_q)
         IDLE: begin
            if (inst_valid_m) begin
               if (!mem_op) begin
                  valid_m = 1'b1;
               end else if (illegal) begin
                  valid_m    = 1'b1;
                  misalign_m = 1'b1;
               end else begin
                  bus_req_valid = 1'b1;
                  bus_req_we    = req_in.we;
                  bus_req_addr  = req_in.addr;
                  bus_req_wdata = req_in.wdata;
                  bus_req_be    = req_in.be;
                  stall_m       = 1'b1;
                  req_d         = req_in;
                  off_d         = ALUResult_m[1:0];
                  f3_d          = funct3_m;
                  state_d       = bus_req_ready ? RSP : REQ;
               end
            end
         end
         REQ: begin
            bus_req_valid = 1'b1;
            stall_m       = 1'b1;
            if (bus_req_ready) state_d = RSP;
         end
         RSP: begin
            stall_m = 1'b1;
            if (bus_rsp_valid) begin
               rdata_d = bus_rsp_rdata;
               state_d = DONE;
            end
         end
         DONE: begin
            valid_m    = 1'b1;
            ReadData_m = req_q.we ? 32'h0 : load_result;
            if (pipe_en) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Hold every output quiet while reset is applied.
      if (rst) begin
         valid_m       = 1'b0;
         stall_m       = 1'b0;
         misalign_m    = 1'b0;
         ReadData_m    = '0;
         bus_req_valid = 1'b0;
      end
   end

   // State and captured-access registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rdata_q <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         req_q   <= req_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        pipe_en;
   logic        inst_valid_m;
   logic [31:0] ALUResult_m;
   logic [31:0] WriteData_m;
   logic        MemRead_m;
   logic        MemWrite_m;
   logic [2:0]  funct3_m;
   logic [31:0] ReadData_m;
   logic        valid_m;
   logic        stall_m;
   logic        misalign_m;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic        bus_req_we;
   logic [31:0] bus_req_addr;
   logic [31:0] bus_req_wdata;
   logic [3:0]  bus_req_be;
   logic        bus_rsp_valid;
   logic [31:0] bus_rsp_rdata;

   int checks;
   int errors;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rsp;
      int          rdy_wait;
      int          rsp_wait;
      int          hold;
      logic        noise;
      logic [31:0] exp_data;
      logic        exp_mis;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_be;
      int          exp_stall;
   } op_t;

   op_t exp_q[$];
   op_t ops[$];

   mem_access_unit #(.DATA_WIDTH(32), .BE_WIDTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .pipe_en       (pipe_en),
      .inst_valid_m  (inst_valid_m),
      .ALUResult_m   (ALUResult_m),
      .WriteData_m   (WriteData_m),
      .MemRead_m     (MemRead_m),
      .MemWrite_m    (MemWrite_m),
      .funct3_m      (funct3_m),
      .ReadData_m    (ReadData_m),
      .valid_m       (valid_m),
      .stall_m       (stall_m),
      .misalign_m    (misalign_m),
      .bus_req_valid (bus_req_valid),
      .bus_req_ready (bus_req_ready),
      .bus_req_we    (bus_req_we),
      .bus_req_addr  (bus_req_addr),
      .bus_req_wdata (bus_req_wdata),
      .bus_req_be    (bus_req_be),
      .bus_rsp_valid (bus_rsp_valid),
      .bus_rsp_rdata (bus_rsp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic op_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rsp,
                              input int rdy_wait, input int rsp_wait, input int hold, input logic noise,
                              input logic [31:0] exp_data, input logic exp_mis, input logic [31:0] exp_addr,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_be, input int exp_stall);
      op_t o;
      o.rd = rd; o.wr = wr; o.f3 = f3; o.addr = addr; o.wdata = wdata; o.rsp = rsp;
      o.rdy_wait = rdy_wait; o.rsp_wait = rsp_wait; o.hold = hold; o.noise = noise;
      o.exp_data = exp_data; o.exp_mis = exp_mis; o.exp_addr = exp_addr;
      o.exp_wdata = exp_wdata; o.exp_be = exp_be; o.exp_stall = exp_stall;
      return o;
   endfunction

   task automatic idle_check();
      inst_valid_m = 1'b0;
      @(negedge clk);
      check("idle_valid", 32'(valid_m), 32'h0);
      check("idle_stall", 32'(stall_m), 32'h0);
      @(posedge clk);
      #1;
   endtask

   // Present one instruction and play the cache side until the result retires with pipe_en high.
   task automatic run_op(input op_t op);
      op_t e;
      int  acc_c, nreq, stalls, nvalid, hold_left;
      bit  accepted, done, seen;
      exp_q.push_back(op);
      inst_valid_m = 1'b1;
      MemRead_m    = op.rd;
      MemWrite_m   = op.wr;
      funct3_m     = op.f3;
      ALUResult_m  = op.addr;
      WriteData_m  = op.wdata;
      accepted = 0; acc_c = -100; nreq = 0; stalls = 0; nvalid = 0;
      hold_left = op.hold; done = 0; seen = 0;
      e = op;
      for (int c = 0; c < 60 && !done; c++) begin
         if (c > 0) begin
            ALUResult_m = $urandom;
            WriteData_m = $urandom;
         end
         bus_req_ready = (c >= op.rdy_wait);
         if (accepted && c == acc_c + op.rsp_wait) begin
            bus_rsp_valid = 1'b1;
            bus_rsp_rdata = op.rsp;
         end else if (op.noise && !(accepted && c > acc_c && c < acc_c + op.rsp_wait)) begin
            bus_rsp_valid = 1'b1;
            bus_rsp_rdata = $urandom;
         end else begin
            bus_rsp_valid = 1'b0;
            bus_rsp_rdata = 32'h0;
         end
         pipe_en = (hold_left == 0);
         @(negedge clk);
         if (stall_m) stalls++;
         if (bus_req_valid) begin
            check("req_addr", bus_req_addr, op.exp_addr);
            check("req_be", 32'(bus_req_be), 32'(op.exp_be));
            check("req_we", 32'(bus_req_we), 32'(op.wr));
            if (op.wr) check("req_wdata", bus_req_wdata, op.exp_wdata);
            if (bus_req_ready) begin
               nreq++;
               accepted = 1;
               acc_c    = c;
            end
         end
         if (valid_m) begin
            if (!seen) begin
               seen = 1;
               e = exp_q.pop_front();
            end
            nvalid++;
            check("read_data", ReadData_m, e.exp_data);
            check("misalign", 32'(misalign_m), 32'(e.exp_mis));
            if (pipe_en) done = 1;
            else hold_left--;
         end
         @(posedge clk);
         #1;
      end
      if (!done) check("timeout", 32'h0, 32'h1);
      check("num_req", 32'(nreq), 32'((op.rd || op.wr) && !op.exp_mis));
      check("valid_cycles", 32'(nvalid), 32'(op.hold + 1));
      check("stall_cycles", 32'(stalls), 32'(op.exp_stall));
      bus_rsp_valid = 1'b0;
      bus_req_ready = 1'b0;
      MemRead_m     = 1'b0;
      MemWrite_m    = 1'b0;
      inst_valid_m  = 1'b0;
      pipe_en       = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1; pipe_en = 1'b1;
      inst_valid_m = 1'b1; MemRead_m = 1'b0; MemWrite_m = 1'b0;
      funct3_m = 3'b010; ALUResult_m = 32'h0; WriteData_m = 32'h0;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0;

      //        rd wr f3      addr          wdata         rsp           rw rs hd nz exp_data      mis addr          wdata         be       st
      ops.push_back(mk(1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, 0, 32'hDEAD_BEEF, 0, 32'h0000_0100, 32'h0,         4'b1111, 2));
      ops.push_back(mk(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 1, 0, 0, 32'hFFFF_FF80, 0, 32'h0000_0100, 32'h0,         4'b1111, 2));
      ops.push_back(mk(1, 0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 1, 0, 0, 32'h0000_0080, 0, 32'h0000_0100, 32'h0,         4'b1111, 2));
      ops.push_back(mk(1, 0, 3'b101, 32'h0000_0102, 32'h0, 32'h80FF_1234, 0, 1, 0, 0, 32'h0000_80FF, 0, 32'h0000_0100, 32'h0,         4'b1111, 2));
      ops.push_back(mk(1, 0, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_1234, 0, 1, 0, 1, 32'hFFFF_80FF, 0, 32'h0000_0100, 32'h0,         4'b1111, 2));
      ops.push_back(mk(1, 0, 3'b000, 32'h0000_0101, 32'h0, 32'h80FF_1234, 0, 1, 0, 0, 32'h0000_0012, 0, 32'h0000_0100, 32'h0,         4'b1111, 2));
      ops.push_back(mk(0, 1, 3'b001, 32'h0000_00A2, 32'h1234_ABCD, 32'h1122_3344, 0, 1, 0, 0, 32'h0, 0, 32'h0000_00A0, 32'hABCD_ABCD, 4'b1100, 2));
      ops.push_back(mk(0, 1, 3'b000, 32'h0000_00A3, 32'h0000_00A5, 32'h1122_3344, 0, 1, 0, 0, 32'h0, 0, 32'h0000_00A0, 32'hA5A5_A5A5, 4'b1000, 2));
      ops.push_back(mk(1, 0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 0, 1, 0, 0, 32'h0, 1, 32'h0, 32'h0, 4'b0000, 0));
      ops.push_back(mk(1, 0, 3'b001, 32'h0000_0101, 32'h0, 32'h0, 0, 1, 0, 0, 32'h0, 1, 32'h0, 32'h0, 4'b0000, 0));
      ops.push_back(mk(1, 0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0, 1, 0, 0, 32'h0, 1, 32'h0, 32'h0, 4'b0000, 0));
      ops.push_back(mk(0, 1, 3'b010, 32'h0000_0201, 32'h5555_AAAA, 32'h0, 0, 1, 0, 0, 32'h0, 1, 32'h0, 32'h0, 4'b0000, 0));
      ops.push_back(mk(0, 1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D, 32'h9999_9999, 3, 2, 2, 1, 32'h0, 0, 32'h0000_0200, 32'hCAFE_F00D, 4'b1111, 6));
      ops.push_back(mk(0, 0, 3'b000, 32'h0000_0040, 32'h0, 32'h0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 4'b0000, 0));
      ops.push_back(mk(1, 0, 3'b101, 32'h0000_0100, 32'h0, 32'h80FF_1234, 1, 3, 0, 1, 32'h0000_1234, 0, 32'h0000_0100, 32'h0,         4'b1111, 5));

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(valid_m), 32'h0);
      check("rst_req_valid", 32'(bus_req_valid), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      inst_valid_m = 1'b0;
      @(negedge clk);
      check("init_valid", 32'(valid_m), 32'h0);
      check("init_stall", 32'(stall_m), 32'h0);
      check("init_misalign", 32'(misalign_m), 32'h0);
      check("init_req_valid", 32'(bus_req_valid), 32'h0);
      check("init_rdata", ReadData_m, 32'h0);
      @(posedge clk);
      #1;

      foreach (ops[i]) begin
         idle_check();
         run_op(ops[i]);
      end

      // Reset while waiting for a response.
      idle_check();
      inst_valid_m = 1'b1; MemRead_m = 1'b1; MemWrite_m = 1'b0;
      funct3_m = 3'b010; ALUResult_m = 32'h0000_0300;
      bus_req_ready = 1'b1; bus_rsp_valid = 1'b0;
      @(negedge clk);
      check("rstseq_req", 32'(bus_req_valid), 32'h1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rstseq_rsp_stall", 32'(stall_m), 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      inst_valid_m = 1'b0; MemRead_m = 1'b0; bus_req_ready = 1'b0;
      @(negedge clk);
      check("rstseq_stall", 32'(stall_m), 32'h0);
      check("rstseq_valid", 32'(valid_m), 32'h0);
      check("rstseq_req_valid", 32'(bus_req_valid), 32'h0);
      @(posedge clk);
      #1;
      run_op(mk(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 4'b0000, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
